// File: rtl/coreriscv_axi4_id_compressor.sv
// Slave-side AXI4 ID compressor: folds wide external IDs onto a small pool of
// narrow internal IDs and restores the wide ID on each response.
module coreriscv_axi4_id_compressor #(
  parameter int WIDE_ID_W   = 5,
  parameter int NARROW_ID_W = 2,
  parameter int MAX_OUT     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_req_valid,
  output logic                   io_req_ready,
  input  logic [WIDE_ID_W-1:0]   io_req_wide_id,
  output logic [NARROW_ID_W-1:0] io_req_narrow_id,
  input  logic                   io_resp_valid,
  input  logic                   io_resp_last,
  input  logic [NARROW_ID_W-1:0] io_resp_narrow_id,
  output logic [WIDE_ID_W-1:0]   io_resp_wide_id,
  output logic                   io_resp_matches,
  output logic                   io_idle
);

  localparam int ENTRIES = 1 << NARROW_ID_W;
  localparam int CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  // Increment is only requested below MAX_CNT and decrement only on a live
  // entry, but both still clamp so the counter can never wrap.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= MAX_CNT) ? MAX_CNT : c + ONE_CNT;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - ONE_CNT;
  endfunction

  logic [ENTRIES-1:0]   valid_q;
  logic [WIDE_ID_W-1:0] wide_id_q [ENTRIES];
  logic [CNT_W-1:0]     cnt_q     [ENTRIES];

  logic                   hit;
  logic [NARROW_ID_W-1:0] hit_idx;
  logic                   free_any;
  logic [NARROW_ID_W-1:0] free_idx;
  logic                   fire;
  logic                   retire;
  logic [ENTRIES-1:0]     inc_vec;
  logic [ENTRIES-1:0]     dec_vec;
  logic [ENTRIES-1:0]     alloc_vec;

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (wide_id_q[i] == io_req_wide_id)) begin
        hit     = 1'b1;
        hit_idx = NARROW_ID_W'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = NARROW_ID_W'(i);
      end
    end
  end

  // Ready is built from table state and the request ID only, never from valid.
  always_comb begin
    io_req_ready     = 1'b0;
    io_req_narrow_id = '0;
    if (hit) begin
      io_req_narrow_id = hit_idx;
      io_req_ready     = (cnt_q[hit_idx] < MAX_CNT);
    end else if (free_any) begin
      io_req_narrow_id = free_idx;
      io_req_ready     = 1'b1;
    end
    if (reset) begin
      io_req_ready = 1'b0;
    end
  end

  assign io_resp_wide_id = wide_id_q[io_resp_narrow_id];
  assign io_resp_matches = valid_q[io_resp_narrow_id];
  assign io_idle         = ~|valid_q;

  assign fire   = io_req_valid & io_req_ready;
  assign retire = io_resp_valid & io_resp_last & io_resp_matches;

  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    alloc_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      inc_vec[i]   = fire & hit & (hit_idx == NARROW_ID_W'(i));
      alloc_vec[i] = fire & ~hit & (free_idx == NARROW_ID_W'(i));
      dec_vec[i]   = retire & (io_resp_narrow_id == NARROW_ID_W'(i));
    end
  end

  // An allocated entry was free, so it can never be retiring in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        wide_id_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (alloc_vec[i]) begin
          valid_q[i]   <= 1'b1;
          wide_id_q[i] <= io_req_wide_id;
          cnt_q[i]     <= ONE_CNT;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_inc(cnt_q[i]);
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt_q[i] <= cnt_dec(cnt_q[i]);
          if (cnt_q[i] == ONE_CNT) begin
            valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
